online_seq_checker_r4: RTL
==========================

Name: online_seq_checker_r4

Overview:
- Sequencer/checker around the radix-4 online adder, driven by the combinational test-vector table.
- Steps testSelect through every test case and latches the table's parallel x, y and expected z.
- Streams x/y digits MSD-first into the adder and samples the adder's serial result digits after the online latency.
- Compares each result digit against z and records a per-test pass/fail summary.

Parameters:
- N, 6, digits per operand; the result has N+1 digits.
- C, 3, bits per digit (two's-complement signed digit, range -3..3).
- LAT, 2, cycles from digit index 0 driven on xd/yd to the first (MSD) result digit valid on zd; must be in 1..8.
- NUM_TESTS, 8, number of test cases run, 1..8.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run the whole suite.
- testSelect  out  3  test index to the vector table.
- x  in  N*C  operand x from the table, MSD in the top bits.
- y  in  N*C  operand y from the table.
- z  in  (N+1)*C  expected sum digits, MSD in the top bits.
- adder_clr  out  1  one-cycle clear of the adder's internal state.
- xd  out  C  serial x digit.
- yd  out  C  serial y digit.
- dig_valid  out  1  xd/yd carry a real operand digit.
- zd  in  C  serial result digit from the adder.
- mismatch  out  1  one-cycle pulse on each compared digit that differs.
- busy  out  1  suite in progress.
- done  out  1  suite finished; holds until the next start.
- pass_count  out  4  number of tests passed.
- fail_mask  out  NUM_TESTS  bit i set means test i failed.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - testSelect=0, k=0.
  - All shift registers cleared.
  - adder_clr=0, xd=yd=0, dig_valid=0, mismatch=0, busy=0, done=0, pass_count=0, fail_mask=0.
  - Reset mid-suite discards all progress; no partial results are retained.
- States: IDLE, LOAD, STREAM, NEXT, DONE.
- IDLE/DONE:
  - start=1: testSelect<=0, pass_count<=0, fail_mask<=0, done<=0, go to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle):
  - The table is combinational on testSelect, which has been stable for at least one cycle.
  - xs<=x, ys<=y, zs<=z, fail<=0, k<=0.
  - adder_clr=1 during this cycle only.
  - Next state STREAM.
- STREAM (k = 0..LAT+N):
  - For k<N: xd = digit k of xs (MSD is k=0), yd likewise, dig_valid=1.
  - For k>=N: xd=yd=0 (flush), dig_valid=0.
  - Shift registers advance one digit per cycle.
  - For LAT<=k<=LAT+N: compare zd against expected digit (k-LAT) of zs, MSD first.
  - On inequality: mismatch pulses for one cycle and fail<=1.
  - When k==LAT+N: go to NEXT; otherwise k<=k+1.
- Comparison rule:
  - Bitwise C-bit equality only. Redundant digit strings with equal value but different digits count as a fail.
  - The value -4 (3'b100) is never expected; if it appears on zd it is simply compared bitwise.
- NEXT (1 cycle):
  - fail_mask[testSelect]<=fail.
  - If !fail: pass_count<=pass_count+1.
  - If testSelect==NUM_TESTS-1: go to DONE, done<=1. Otherwise testSelect<=testSelect+1 and go to LOAD.
- busy=1 in LOAD, STREAM and NEXT.
- Timing per test: LAT+N+3 cycles (11 at defaults).
  - The suite takes NUM_TESTS*(LAT+N+3) cycles after the start edge; done rises on the following edge.
  - At defaults: 88 cycles, done high on edge 89.
- testSelect never exceeds NUM_TESTS-1 and does not wrap while busy.

Test Plan:
- Reset, then idle for 5 cycles -> testSelect=0, busy=0, done=0, pass_count=0, fail_mask=0, xd=yd=0, dig_valid=0.
- Start with a bench golden adder model (LAT=2) and the defaults -> busy high for 88 cycles, done=1 after that, pass_count=8, fail_mask=8'h00, no mismatch pulses.
- Digit order, test 1:
  - xd over k=0..5 is 1,2,5,3,0,7; yd is 2,7,5,3,2,2; dig_valid=1.
  - k=6..8 gives xd=yd=0, dig_valid=0.
  - adder_clr pulses exactly once per test, in the LOAD cycle.
- Fault injection: model forces the test-4 LSD to 0 instead of -1 (7) -> one mismatch pulse at k=8 of test 4, fail_mask=8'h10, pass_count=7, done asserted.
- Assert rst during STREAM of test 5 -> outputs immediately at reset values. A later start reruns from testSelect=0 and finishes with pass_count=8.
- Pulse start while busy (test 2) -> no effect, suite completes normally.
  - start while done=1 -> done drops the next cycle and counters clear.
  - A second full run repeats pass_count=8.

Source files
------------

// File: rtl/online_seq_checker_r4_if.sv
// Bus between the sequencer/checker, the test-vector table and the online adder.
// master: the checker. slave: the environment (table, adder, control).
interface online_seq_checker_r4_if #(
  parameter int N         = 6,
  parameter int C         = 3,
  parameter int NUM_TESTS = 8
);
  logic                   start;
  logic [2:0]             testSelect;
  logic [N*C-1:0]         x;
  logic [N*C-1:0]         y;
  logic [(N+1)*C-1:0]     z;
  logic                   adder_clr;
  logic [C-1:0]           xd;
  logic [C-1:0]           yd;
  logic                   dig_valid;
  logic [C-1:0]           zd;
  logic                   mismatch;
  logic                   busy;
  logic                   done;
  logic [3:0]             pass_count;
  logic [NUM_TESTS-1:0]   fail_mask;

  modport master (
    input  start, x, y, z, zd,
    output testSelect, adder_clr, xd, yd, dig_valid, mismatch,
           busy, done, pass_count, fail_mask
  );

  modport slave (
    output start, x, y, z, zd,
    input  testSelect, adder_clr, xd, yd, dig_valid, mismatch,
           busy, done, pass_count, fail_mask
  );
endinterface

// File: rtl/online_seq_checker_r4.sv
// Sequencer/checker for the radix-4 online adder: walks every table entry,
// streams x/y digits MSD-first, and compares the serial result against z.
module online_seq_checker_r4 #(
  parameter int N         = 6,
  parameter int C         = 3,
  parameter int LAT       = 2,
  parameter int NUM_TESTS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  online_seq_checker_r4_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // k runs 0..LAT+N inside STREAM
  localparam int KW = $clog2(LAT + N + 1);
  localparam logic [KW-1:0] K_LAT  = KW'(LAT);
  localparam logic [KW-1:0] K_N    = KW'(N);
  localparam logic [KW-1:0] K_LAST = KW'(LAT + N);
  localparam logic [2:0]    T_LAST = 3'(NUM_TESTS - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [KW-1:0]          r_k;
  logic [N*C-1:0]         r_xs;
  logic [N*C-1:0]         r_ys;
  logic [(N+1)*C-1:0]     r_zs;
  logic                   r_fail;
  logic [2:0]             r_ts;
  logic                   r_done;
  logic [3:0]             r_pass;
  logic [NUM_TESTS-1:0]   r_mask;

  logic                   w_stream;
  logic                   w_cmp;
  logic                   w_mis;

  // Result digits are compared from k=LAT onward; bitwise equality only,
  // so redundant encodings of the same value still count as a failure.
  assign w_stream = (r_state == S_STREAM);
  assign w_cmp    = w_stream && (r_k >= K_LAT);
  assign w_mis    = w_cmp && (bus.zd != r_zs[(N+1)*C-1 -: C]);

  // Operand shift registers fill with zeros, so the flush digits come for free.
  assign bus.xd         = w_stream ? r_xs[N*C-1 -: C] : {C{1'b0}};
  assign bus.yd         = w_stream ? r_ys[N*C-1 -: C] : {C{1'b0}};
  assign bus.dig_valid  = w_stream && (r_k < K_N);
  assign bus.adder_clr  = (r_state == S_LOAD);
  assign bus.mismatch   = w_mis;
  assign bus.busy       = (r_state == S_LOAD) || w_stream || (r_state == S_NEXT);
  assign bus.testSelect = r_ts;
  assign bus.done       = r_done;
  assign bus.pass_count = r_pass;
  assign bus.fail_mask  = r_mask;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next = S_LOAD;
        else           w_next = r_state;
      end
      S_LOAD:   w_next = S_STREAM;
      S_STREAM: begin
        if (r_k == K_LAST) w_next = S_NEXT;
        else               w_next = S_STREAM;
      end
      S_NEXT: begin
        if (r_ts == T_LAST) w_next = S_DONE;
        else                w_next = S_LOAD;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: table latch, digit shifting, per-test verdict and suite summary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= {KW{1'b0}};
      r_xs   <= {(N*C){1'b0}};
      r_ys   <= {(N*C){1'b0}};
      r_zs   <= {((N+1)*C){1'b0}};
      r_fail <= 1'b0;
      r_ts   <= 3'd0;
      r_done <= 1'b0;
      r_pass <= 4'd0;
      r_mask <= {NUM_TESTS{1'b0}};
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_ts   <= 3'd0;
            r_pass <= 4'd0;
            r_mask <= {NUM_TESTS{1'b0}};
            r_done <= 1'b0;
          end
        end
        S_LOAD: begin
          r_xs   <= bus.x;
          r_ys   <= bus.y;
          r_zs   <= bus.z;
          r_fail <= 1'b0;
          r_k    <= {KW{1'b0}};
        end
        S_STREAM: begin
          r_xs <= {r_xs[N*C-C-1:0], {C{1'b0}}};
          r_ys <= {r_ys[N*C-C-1:0], {C{1'b0}}};
          if (w_cmp) r_zs <= {r_zs[(N+1)*C-C-1:0], {C{1'b0}}};
          if (w_mis) r_fail <= 1'b1;
          if (r_k != K_LAST) r_k <= r_k + KW'(1);
        end
        S_NEXT: begin
          for (int i = 0; i < NUM_TESTS; i++) begin
            if (r_ts == 3'(i)) r_mask[i] <= r_fail;
          end
          if (!r_fail) r_pass <= r_pass + 4'd1;
          if (r_ts == T_LAST) r_done <= 1'b1;
          else                r_ts   <= r_ts + 3'd1;
        end
        default: begin
          r_k <= {KW{1'b0}};
        end
      endcase
    end
  end

endmodule
